// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master, its clock generator and the slave model.
// Bit order is selected by SPI_LSB_FIRST_EN (default: MSB first).
package spi_pkg;
  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  localparam logic SCK_IDLE    = 1'b0;
  localparam logic CS_INACTIVE = 1'b1;
endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer: tick every CLK_DIV cycles while running, rise/fall strobes in SHIFT.
// half_cnt counts completed SHIFT half-periods; even values are low phases.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 1,
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
  localparam int HALF_W = $clog2(2 * DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              shift,
  output logic              tick,
  output logic              sck_rise,
  output logic              sck_fall,
  output logic [HALF_W-1:0] half_cnt
);
  logic [DIV_W-1:0] div_cnt;

  assign tick     = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise = shift && tick && !half_cnt[0];
  assign sck_fall = shift && tick && half_cnt[0];

  always_ff @(posedge clk) begin
    if (rst || !run || tick) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !shift) half_cnt <= '0;
    else if (tick)     half_cnt <= half_cnt + 1'b1;
  end
endmodule

// File: rtl/spi_slave.sv
// Mode-0 shift-register slave: samples MOSI on SCK rise, launches MISO on SCK fall.
// DIN updates when CS deasserts; honours SPI_LSB_FIRST_EN like the master.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DOUT
);
  logic [CNT_W-1:0]  fall_cnt;
  logic [DATA_W-1:0] rx_q;

  always_ff @(negedge SCK or posedge CS) begin
    if (CS == CS_INACTIVE) fall_cnt <= '0;
    else                   fall_cnt <= fall_cnt + 1'b1;
  end

  always_comb begin
    MISO = 1'b0;
    if (fall_cnt < CNT_W'(DATA_W)) begin
`ifdef SPI_LSB_FIRST_EN
      MISO = DOUT[fall_cnt];
`else
      MISO = DOUT[CNT_W'(DATA_W - 1) - fall_cnt];
`endif
    end
  end

  always_ff @(posedge SCK) begin
`ifdef SPI_LSB_FIRST_EN
    rx_q <= {MOSI, rx_q[DATA_W-1:1]};
`else
    rx_q <= {rx_q[DATA_W-2:0], MOSI};
`endif
  end

  always_ff @(posedge CS) DIN <= rx_q;
endmodule

// File: rtl/spi_master.sv
// Single-transfer SPI mode-0 master; START accepted only in IDLE, BUSY covers SETUP..DONE.
// SPI_LSB_FIRST_EN selects LSB-first shifting; timing is identical either way.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  input  logic [DATA_W-1:0] DOUT,
  output logic [DATA_W-1:0] DIN,
  output logic              SCK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int HALF_W = $clog2(2 * DATA_W + 1);
`ifdef SPI_LSB_FIRST_EN
  localparam int FIRST_BIT = 0;
`else
  localparam int FIRST_BIT = DATA_W - 1;
`endif

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, din_q, din_d;
  logic              sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d;
  logic              tick, sck_rise, sck_fall;
  logic [HALF_W-1:0] half_cnt;
  logic              last_fall;

  spi_clk_gen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (CLK),
    .rst      (RST),
    .run      (state_q != IDLE),
    .shift    (state_q == SHIFT),
    .tick     (tick),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .half_cnt (half_cnt)
  );

  assign last_fall = sck_fall && (half_cnt == HALF_W'(2 * DATA_W - 1));

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    din_d   = din_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          tx_d    = DOUT;
          rx_d    = '0;
          cs_d    = ~CS_INACTIVE;
          busy_d  = 1'b1;
          mosi_d  = DOUT[FIRST_BIT];
          state_d = SETUP;
        end
      end
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: begin
        if (sck_rise) sck_d = ~SCK_IDLE;
        if (sck_fall) begin
          sck_d = SCK_IDLE;
`ifdef SPI_LSB_FIRST_EN
          rx_d = {MISO, rx_q[DATA_W-1:1]};
          tx_d = {1'b0, tx_q[DATA_W-1:1]};
`else
          rx_d = {rx_q[DATA_W-2:0], MISO};
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
`endif
          mosi_d = tx_d[FIRST_BIT];
          if (last_fall) state_d = DONE;
        end
      end
      DONE: begin
        // CS is held low for one more half-period after the last falling edge.
        if (tick) begin
          din_d   = rx_q;
          cs_d    = CS_INACTIVE;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      din_q   <= '0;
      sck_q   <= SCK_IDLE;
      cs_q    <= CS_INACTIVE;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      din_q   <= din_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

  assign BUSY = busy_q;
  assign DIN  = din_q;
  assign SCK  = sck_q;
  assign CS   = cs_q;
  assign MOSI = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with spi_slave peers at CLK_DIV=1 and CLK_DIV=4.
// Expected MOSI bit patterns follow SPI_LSB_FIRST_EN.
module tb_spi_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start4 = 1'b0;
  logic [7:0] dout = '0, sdout = '0, dout4 = '0, sdout4 = '0;
  logic [7:0] din, sdin, din4, sdin4;
  logic       busy, sck, cs, mosi, miso;
  logic       busy4, sck4, cs4, mosi4, miso4;
  int         n_checks = 0;
  int         n_fail = 0;

`ifdef SPI_LSB_FIRST_EN
  localparam logic [7:0] BITS_56 = 8'h6A;
`else
  localparam logic [7:0] BITS_56 = 8'h56;
`endif

  always #5 clk = ~clk;

  spi_master #(.DATA_W(8), .CLK_DIV(1)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DOUT(dout), .DIN(din),
    .SCK(sck), .CS(cs), .MOSI(mosi), .MISO(miso)
  );
  spi_slave #(.DATA_W(8)) slv (
    .SCK(sck), .CS(cs), .MOSI(mosi), .MISO(miso), .DIN(sdin), .DOUT(sdout)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .BUSY(busy4), .DOUT(dout4), .DIN(din4),
    .SCK(sck4), .CS(cs4), .MOSI(mosi4), .MISO(miso4)
  );
  spi_slave #(.DATA_W(8)) slv4 (
    .SCK(sck4), .CS(cs4), .MOSI(mosi4), .MISO(miso4), .DIN(sdin4), .DOUT(sdout4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where BUSY is first seen low.
  task automatic run_xfer(input logic [7:0] m, input logic [7:0] s, input int extra_at,
                          input logic [7:0] exp_bits, input string tag);
    int         busy_n = 0;
    int         rises = 0;
    int         cs_bad = 0;
    logic       prev_sck = 1'b0;
    logic [7:0] bits = '0;
    dout  = m;
    sdout = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      busy_n++;
      if (cs !== 1'b0) cs_bad++;
      if (sck && !prev_sck) begin
        bits = {bits[6:0], mosi};
        rises++;
        if (rises == extra_at) start = 1'b1;
      end else begin
        start = 1'b0;
      end
      prev_sck = sck;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, busy_n, 18);
    check({tag, "_sck_rises"}, rises, 8);
    check({tag, "_mosi_bits"}, {24'd0, bits}, {24'd0, exp_bits});
    check({tag, "_cs_low_while_busy"}, cs_bad, 0);
    check({tag, "_cs_idle"}, {31'd0, cs}, 1);
    check({tag, "_master_din"}, {24'd0, din}, {24'd0, s});
    check({tag, "_slave_din"}, {24'd0, sdin}, {24'd0, m});
  endtask

  initial begin
    int         rises;
    int         busy_n;
    int         first_rise;
    int         first_fall;
    logic       prev;
    logic [7:0] bits;

    repeat (2) @(negedge clk);
    check("rst_sck", {31'd0, sck}, 0);
    check("rst_cs", {31'd0, cs}, 1);
    check("rst_mosi", {31'd0, mosi}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_din", {24'd0, din}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(8'h56, 8'h34, 0, BITS_56, "basic");
    @(negedge clk);

    for (int k = 0; k < 3; k++) run_xfer(8'h56, 8'h34, 0, BITS_56, "b2b");

    repeat (2) @(negedge clk);
    run_xfer(8'h56, 8'h34, 3, BITS_56, "start_busy");
    busy_n = 0;
    repeat (5) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    check("start_busy_no_restart", busy_n, 0);

    dout  = 8'h56;
    sdout = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sck && !prev) rises++;
      prev = sck;
      if (rises == 4) break;
      @(negedge clk);
    end
    check("abort_rises", rises, 4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sck", {31'd0, sck}, 0);
    check("abort_cs", {31'd0, cs}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_din", {24'd0, din}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(8'hA5, 8'h3C, 0, 8'hA5, "post_abort");

    @(negedge clk);
    dout4  = 8'hFF;
    sdout4 = 8'h00;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    busy_n = 0;
    rises = 0;
    first_rise = -1;
    first_fall = -1;
    prev = 1'b0;
    bits = '0;
    for (int i = 0; i < 400 && busy4; i++) begin
      busy_n++;
      if (sck4 && !prev) begin
        rises++;
        bits = {bits[6:0], mosi4};
        if (first_rise < 0) first_rise = i;
      end
      if (!sck4 && prev && first_fall < 0) first_fall = i;
      prev = sck4;
      @(negedge clk);
    end
    check("div4_busy_cycles", busy_n, 72);
    check("div4_sck_rises", rises, 8);
    check("div4_mosi_bits", {24'd0, bits}, 32'hFF);
    check("div4_half_period", first_fall - first_rise, 4);
    check("div4_master_din", {24'd0, din4}, 0);
    check("div4_slave_din", {24'd0, sdin4}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
